// File: rtl/uart_denetleyici.sv
// uart_denetleyici: memory-mapped 8N1 UART with a TX FIFO and an RX holding register or FIFO.
// Optional feature macro: UART_RX_FIFO_EN selects an 8-entry RX FIFO instead of a single holding register.
// Ports: clk (rising edge), resetn (asynchronous, active low);
//        iomem_valid/iomem_ready/iomem_wstrb/iomem_addr/iomem_wdata/iomem_rdata - simple memory bus,
//        iomem_ready is a one-cycle pulse one cycle after iomem_valid, rdata valid with it;
//        uart_tx_o - serial out, idle high; uart_rx_i - asynchronous serial in.
// Registers: 0x0 KONTROL {rx_en, tx_en, divisor[15:0]}, 0x4 DURUM (w1c for bits 3/4),
//            0x8 TX_VERI (write pushes byte), 0xC RX_VERI (read pops byte).
module uart_denetleyici #(
    parameter int          TX_DERINLIK = 8,
    parameter logic [15:0] BOLEN_RESET = 16'd868
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        uart_tx_o,
    input  logic        uart_rx_i
);
    localparam int AW = $clog2(TX_DERINLIK);
    typedef enum logic [1:0] {BOSTA, BASLA, VERI, DUR} durum_t;
    logic          r_ready, r_tx_en, r_rx_en, r_overrun, r_cerceve;
    logic [31:0]   r_rdata;
    logic [15:0]   r_bolen;
    logic          w_acc, w_yaz, w_oku, w_w1c, w_unused;
    logic [15:0]   w_bol;
    logic [31:0]   w_okuma;
    logic [7:0]    r_tx_mem [TX_DERINLIK];
    logic [AW-1:0] r_tx_rd, r_tx_wr;
    logic [AW:0]   r_tx_say;
    logic          w_tx_dolu, w_tx_bos, w_tx_push, w_tx_pop, w_tx_son;
    durum_t        r_tx_durum, w_tx_sonraki;
    logic [15:0]   r_tx_sayac, r_tx_bol;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_sr;
    logic          r_rx_s1, r_rx_s2, r_rx_onceki;
    durum_t        r_rx_durum, w_rx_sonraki;
    logic [15:0]   r_rx_sayac, r_rx_bol;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_sr;
    logic          w_rx_son, w_rx_yari, w_rx_yaz, w_rx_cerceve, w_rx_pop, w_rx_gecerli, w_rx_tasma;
    logic [7:0]    w_rx_bayt;

    // A request is taken only when ready is low, so the ready cycle never starts a second access.
    assign w_acc = iomem_valid & ~r_ready;
    assign w_yaz = w_acc & (|iomem_wstrb);
    assign w_oku = w_acc & ~(|iomem_wstrb);
    assign w_w1c = w_yaz & (iomem_addr[3:2] == 2'd1) & iomem_wstrb[0];
    assign w_bol = (r_bolen < 16'd4) ? 16'd4 : r_bolen;
    assign w_unused = ^{iomem_addr[31:4], iomem_addr[1:0], iomem_wdata[31:18]};
    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign w_okuma = (iomem_addr[3:2] == 2'd0) ? {14'd0, r_rx_en, r_tx_en, r_bolen}
                   : (iomem_addr[3:2] == 2'd1) ? {26'd0, r_tx_durum != BOSTA, r_cerceve, r_overrun,
                                                  w_rx_gecerli, w_tx_bos, w_tx_dolu}
                   : (iomem_addr[3:2] == 2'd3) ? {24'd0, w_rx_gecerli ? w_rx_bayt : 8'd0} : 32'd0;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            r_ready   <= 1'b0;
            r_rdata   <= 32'd0;
            r_bolen   <= BOLEN_RESET;
            r_tx_en   <= 1'b1;
            r_rx_en   <= 1'b1;
            r_overrun <= 1'b0;
            r_cerceve <= 1'b0;
        end else begin
            r_ready <= w_acc;
            r_rdata <= w_oku ? w_okuma : 32'd0;
            if (w_yaz && iomem_addr[3:2] == 2'd0) begin
                if (iomem_wstrb[0]) r_bolen[7:0] <= iomem_wdata[7:0];
                if (iomem_wstrb[1]) r_bolen[15:8] <= iomem_wdata[15:8];
                if (iomem_wstrb[2]) {r_rx_en, r_tx_en} <= iomem_wdata[17:16];
            end
            // A new event wins over a same-cycle clear so it is never lost.
            r_overrun <= w_rx_tasma | (r_overrun & ~(w_w1c & iomem_wdata[3]));
            r_cerceve <= w_rx_cerceve | (r_cerceve & ~(w_w1c & iomem_wdata[4]));
        end

    assign w_tx_dolu = r_tx_say == (AW+1)'(TX_DERINLIK);
    assign w_tx_bos  = r_tx_say == '0;
    assign w_tx_push = w_yaz & (iomem_addr[3:2] == 2'd2) & iomem_wstrb[0] & (~w_tx_dolu | w_tx_pop);

    always_ff @(posedge clk)
        if (w_tx_push) r_tx_mem[r_tx_wr] <= iomem_wdata[7:0];

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            r_tx_rd  <= '0;
            r_tx_wr  <= '0;
            r_tx_say <= '0;
        end else begin
            r_tx_wr  <= r_tx_wr + AW'(w_tx_push);
            r_tx_rd  <= r_tx_rd + AW'(w_tx_pop);
            r_tx_say <= r_tx_say + (AW+1)'(w_tx_push) - (AW+1)'(w_tx_pop);
        end

    assign w_tx_son = r_tx_sayac == r_tx_bol - 16'd1;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) r_tx_durum <= BOSTA;
        else r_tx_durum <= w_tx_sonraki;

    always_comb begin
        w_tx_sonraki = r_tx_durum;
        w_tx_pop = 1'b0;
        case (r_tx_durum)
            BOSTA: if (r_tx_en && !w_tx_bos) begin
                w_tx_sonraki = BASLA;
                w_tx_pop = 1'b1;
            end
            BASLA: if (w_tx_son) w_tx_sonraki = VERI;
            VERI: if (w_tx_son && r_tx_bit == 3'd7) w_tx_sonraki = DUR;
            default: if (w_tx_son) begin
                w_tx_sonraki = (r_tx_en && !w_tx_bos) ? BASLA : BOSTA;
                w_tx_pop = r_tx_en && !w_tx_bos;
            end
        endcase
    end

    // The divisor is captured with each popped byte, so KONTROL edits never stretch a frame in flight.
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            r_tx_sayac <= 16'd0;
            r_tx_bol   <= 16'd4;
            r_tx_bit   <= 3'd0;
            r_tx_sr    <= 8'd0;
        end else if (w_tx_pop) begin
            r_tx_sayac <= 16'd0;
            r_tx_bol   <= w_bol;
            r_tx_sr    <= r_tx_mem[r_tx_rd];
        end else if (r_tx_durum != BOSTA) begin
            r_tx_sayac <= w_tx_son ? 16'd0 : r_tx_sayac + 16'd1;
            if (r_tx_durum == VERI && w_tx_son) begin
                r_tx_sr  <= r_tx_sr >> 1;
                r_tx_bit <= r_tx_bit + 3'd1;
            end
        end

    assign uart_tx_o = (r_tx_durum == BASLA) ? 1'b0 : (r_tx_durum == VERI) ? r_tx_sr[0] : 1'b1;

    assign w_rx_son  = r_rx_sayac == r_rx_bol - 16'd1;
    assign w_rx_yari = r_rx_sayac == (r_rx_bol >> 1) - 16'd1;
    assign w_rx_pop  = w_oku & (iomem_addr[3:2] == 2'd3) & w_rx_gecerli;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) r_rx_durum <= BOSTA;
        else r_rx_durum <= w_rx_sonraki;

    always_comb begin
        w_rx_sonraki = r_rx_durum;
        w_rx_yaz = 1'b0;
        w_rx_cerceve = 1'b0;
        case (r_rx_durum)
            BOSTA: if (r_rx_en && r_rx_onceki && !r_rx_s2) w_rx_sonraki = BASLA;
            BASLA: if (w_rx_yari) w_rx_sonraki = r_rx_s2 ? BOSTA : VERI;
            VERI: if (w_rx_son && r_rx_bit == 3'd7) w_rx_sonraki = DUR;
            default: if (w_rx_son) begin
                w_rx_sonraki = BOSTA;
                w_rx_yaz = r_rx_s2;
                w_rx_cerceve = ~r_rx_s2;
            end
        endcase
    end

    // The divisor is reloaded every idle cycle; the value seen on the start edge holds for the frame.
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_rx_onceki <= 1'b1;
            r_rx_sayac  <= 16'd0;
            r_rx_bol    <= 16'd4;
            r_rx_bit    <= 3'd0;
            r_rx_sr     <= 8'd0;
        end else begin
            r_rx_s1     <= uart_rx_i;
            r_rx_s2     <= r_rx_s1;
            r_rx_onceki <= r_rx_s2;
            if (r_rx_durum == BOSTA) begin
                r_rx_sayac <= 16'd0;
                r_rx_bol   <= w_bol;
                r_rx_bit   <= 3'd0;
            end else begin
                r_rx_sayac <= ((r_rx_durum == BASLA) ? w_rx_yari : w_rx_son) ? 16'd0 : r_rx_sayac + 16'd1;
                if (r_rx_durum == VERI && w_rx_son) begin
                    r_rx_sr  <= {r_rx_s2, r_rx_sr[7:1]};
                    r_rx_bit <= r_rx_bit + 3'd1;
                end
            end
        end

`ifdef UART_RX_FIFO_EN
    logic [7:0] r_rx_mem [8];
    logic [2:0] r_rx_rd, r_rx_wr;
    logic [3:0] r_rx_say;
    logic       w_rx_push;
    assign w_rx_gecerli = r_rx_say != 4'd0;
    assign w_rx_bayt    = r_rx_mem[r_rx_rd];
    assign w_rx_push    = w_rx_yaz & ((r_rx_say != 4'd8) | w_rx_pop);
    assign w_rx_tasma   = w_rx_yaz & ~w_rx_push;

    always_ff @(posedge clk)
        if (w_rx_push) r_rx_mem[r_rx_wr] <= r_rx_sr;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            r_rx_rd  <= 3'd0;
            r_rx_wr  <= 3'd0;
            r_rx_say <= 4'd0;
        end else begin
            r_rx_wr  <= r_rx_wr + 3'(w_rx_push);
            r_rx_rd  <= r_rx_rd + 3'(w_rx_pop);
            r_rx_say <= r_rx_say + 4'(w_rx_push) - 4'(w_rx_pop);
        end
`else
    logic [7:0] r_rx_veri;
    logic       r_rx_dolu;
    assign w_rx_gecerli = r_rx_dolu;
    assign w_rx_bayt    = r_rx_veri;
    assign w_rx_tasma   = w_rx_yaz & r_rx_dolu & ~w_rx_pop;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            r_rx_veri <= 8'd0;
            r_rx_dolu <= 1'b0;
        end else begin
            if (w_rx_yaz && !w_rx_tasma) r_rx_veri <= r_rx_sr;
            r_rx_dolu <= (w_rx_yaz & ~w_rx_tasma) | (r_rx_dolu & ~w_rx_pop);
        end
`endif
endmodule

// File: tb/tb_uart_denetleyici.sv
// tb_uart_denetleyici: self-checking bench for uart_denetleyici using a frame-level serial model.
module tb_uart_denetleyici;
    logic        clk = 0, resetn = 0, iomem_valid = 0, rx_surucu = 1, geri_dongu = 0;
    logic        iomem_ready, uart_tx_o, uart_rx_i;
    logic [3:0]  iomem_wstrb = 0;
    logic [31:0] iomem_addr = 0, iomem_wdata = 0, iomem_rdata;
    int          hata = 0, kontrol = 0;
    logic        cap [400];
    bit          bulundu;

    assign uart_rx_i = geri_dongu ? uart_tx_o : rx_surucu;
    always #5 clk = ~clk;

    uart_denetleyici dut (
        .clk(clk), .resetn(resetn),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .uart_tx_o(uart_tx_o), .uart_rx_i(uart_rx_i)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [31:0] r);
        int n = 0;
        @(negedge clk);
        iomem_valid = 1; iomem_addr = a; iomem_wdata = d; iomem_wstrb = s;
        do begin @(negedge clk); n++; end while (!iomem_ready && n < 8);
        r = iomem_rdata;
        iomem_valid = 0; iomem_wstrb = 0;
        if (!iomem_ready) begin
            kontrol++; hata++;
            $display("FAIL bus_timeout: ready=%b expected 1 addr=%h", iomem_ready, a);
        end
    endtask

    task automatic yaz(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        bus(a, d, s, r);
    endtask

    task automatic oku(input logic [31:0] a, output logic [31:0] r);
        bus(a, 32'd0, 4'd0, r);
    endtask

    // Waits (bounded) for a start bit, then records n consecutive per-cycle line samples.
    task automatic tx_yakala(input int n);
        int t = 0;
        while (uart_tx_o && t < 3000) begin @(negedge clk); t++; end
        bulundu = !uart_tx_o;
        for (int i = 0; i < n; i++) begin cap[i] = uart_tx_o; @(negedge clk); end
    endtask

    task automatic rx_gonder(input logic [7:0] b, input int d, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin rx_surucu = f[i]; repeat (d) @(negedge clk); end
        rx_surucu = 1;
    endtask

    // Line level of bit i of an 8N1 frame: start, 8 data bits LSB first, stop.
    function automatic logic beklenen(input logic [7:0] b, input int i);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        return f[i];
    endfunction

    task automatic test_reset;
        logic [31:0] r;
        repeat (3) @(negedge clk);
        kontrol++;
        if (iomem_ready !== 1'b0 || uart_tx_o !== 1'b1 || iomem_rdata !== 32'd0) begin
            hata++;
            $display("FAIL reset_outputs: ready=%b tx=%b rdata=%h expected 0 1 00000000", iomem_ready, uart_tx_o, iomem_rdata);
        end
        resetn = 1;
        oku(32'h0, r); kontrol++;
        if (r !== 32'h00030364) begin hata++; $display("FAIL reset_kontrol: got %h expected 00030364", r); end
        oku(32'h4, r); kontrol++;
        if (r !== 32'h2) begin hata++; $display("FAIL reset_durum: got %h expected 00000002", r); end
        oku(32'hC, r); kontrol++;
        if (r !== 32'h0) begin hata++; $display("FAIL empty_rx_read: got %h expected 00000000", r); end
        oku(32'h8, r); kontrol++;
        if (r !== 32'h0) begin hata++; $display("FAIL tx_veri_read: got %h expected 00000000", r); end
        oku(32'h4, r); kontrol++;
        if (r !== 32'h2) begin hata++; $display("FAIL durum_after_empty_pop: got %h expected 00000002", r); end
    endtask

    task automatic test_bus_timing;
        @(negedge clk);
        iomem_valid = 1; iomem_addr = 32'h0; iomem_wstrb = 0;
        @(negedge clk); kontrol++;
        if (iomem_ready !== 1'b1) begin hata++; $display("FAIL ready_latency: got %b expected 1", iomem_ready); end
        kontrol++;
        if (iomem_rdata !== 32'h00030364) begin hata++; $display("FAIL rdata_with_ready: got %h expected 00030364", iomem_rdata); end
        @(negedge clk); kontrol++;
        if (iomem_ready !== 1'b0) begin hata++; $display("FAIL ready_single_pulse: got %b expected 0", iomem_ready); end
        iomem_valid = 0;
    endtask

    task automatic test_kontrol;
        logic [31:0] m, r, d;
        logic [3:0] s;
        m = 32'h00030364;
        repeat (6) begin
            d = $urandom;
            s = 4'($urandom_range(1, 15));
            yaz(32'h0, d, s);
            for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
            m &= 32'h0003FFFF;
            oku(32'h0, r); kontrol++;
            if (r !== m) begin hata++; $display("FAIL kontrol_strobe: got %h expected %h strb=%b", r, m, s); end
        end
        yaz(32'h0, 32'h00030004, 4'hF);
    endtask

    task automatic test_tx_055;
        logic [31:0] r;
        logic [3:0] g;
        yaz(32'h0, 32'h00030004, 4'hF);
        yaz(32'h8, 32'h55, 4'h1);
        tx_yakala(44);
        kontrol++;
        if (!bulundu) begin hata++; $display("FAIL tx55_start: got no start bit expected one"); end
        for (int b = 0; b < 10; b++) begin
            g = {cap[4*b+3], cap[4*b+2], cap[4*b+1], cap[4*b]};
            kontrol++;
            if (g !== {4{beklenen(8'h55, b)}}) begin
                hata++; $display("FAIL tx55_bit%0d: got %b expected %b", b, g, {4{beklenen(8'h55, b)}});
            end
        end
        g = {cap[43], cap[42], cap[41], cap[40]};
        kontrol++;
        if (g !== 4'hF) begin hata++; $display("FAIL tx55_idle_after: got %b expected 1111", g); end
        oku(32'h4, r); kontrol++;
        if (r !== 32'h2) begin hata++; $display("FAIL tx55_durum: got %h expected 00000002", r); end
    endtask

    task automatic test_tx_rastgele;
        int d, e, bad;
        logic [7:0] b;
        repeat (4) begin
            d = $urandom_range(0, 9);
            e = (d < 4) ? 4 : d;
            b = 8'($urandom);
            yaz(32'h0, 32'h00030000 | d, 4'hF);
            yaz(32'h8, {24'd0, b}, 4'h1);
            tx_yakala(10 * e);
            bad = 0;
            for (int i = 0; i < 10 * e; i++) if (cap[i] !== beklenen(b, i / e)) bad++;
            kontrol++;
            if (!bulundu || bad != 0) begin
                hata++; $display("FAIL tx_frame: got %0d wrong cycles (start=%b) expected 0, div=%0d byte=%h", bad, bulundu, d, b);
            end
        end
    endtask

    task automatic test_fifo_full;
        logic [7:0] q[$];
        logic [7:0] b;
        logic [31:0] r;
        int bad;
        yaz(32'h0, 32'h00020004, 4'hF);
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            yaz(32'h8, {24'd0, b}, 4'h1);
            if (q.size() < 8) q.push_back(b);
        end
        oku(32'h4, r); kontrol++;
        if (r !== 32'h1) begin hata++; $display("FAIL fifo_full_durum: got %h expected 00000001", r); end
        yaz(32'h0, 32'h00030004, 4'hF);
        tx_yakala(380);
        kontrol++;
        if (!bulundu) begin hata++; $display("FAIL fifo_start: got no start bit expected one"); end
        for (int f = 0; f < 8; f++) begin
            bad = 0;
            for (int c = 0; c < 40; c++) if (cap[40*f + c] !== beklenen(q[f], c / 4)) bad++;
            kontrol++;
            if (bad != 0) begin hata++; $display("FAIL fifo_frame%0d: got %0d wrong cycles expected 0 byte=%h", f, bad, q[f]); end
        end
        bad = 0;
        for (int c = 320; c < 380; c++) if (cap[c] !== 1'b1) bad++;
        kontrol++;
        if (bad != 0) begin hata++; $display("FAIL fifo_ninth_dropped: got %0d low cycles expected 0", bad); end
        oku(32'h4, r); kontrol++;
        if (r !== 32'h2) begin hata++; $display("FAIL fifo_drained_durum: got %h expected 00000002", r); end
    endtask

    task automatic test_loopback;
        logic [31:0] r;
        logic [7:0] b;
        int d;
        geri_dongu = 1;
        yaz(32'h0, 32'h00030008, 4'hF);
        yaz(32'h8, 32'hA3, 4'h1);
        repeat (120) @(negedge clk);
        oku(32'h4, r); kontrol++;
        if (r !== 32'h6) begin hata++; $display("FAIL loop_durum_valid: got %h expected 00000006", r); end
        oku(32'hC, r); kontrol++;
        if (r !== 32'hA3) begin hata++; $display("FAIL loop_rx_veri: got %h expected 000000a3", r); end
        oku(32'h4, r); kontrol++;
        if (r !== 32'h2) begin hata++; $display("FAIL loop_durum_popped: got %h expected 00000002", r); end
        repeat (3) begin
            d = $urandom_range(4, 12);
            b = 8'($urandom);
            yaz(32'h0, 32'h00030000 | d, 4'hF);
            yaz(32'h8, {24'd0, b}, 4'h1);
            repeat (12 * d + 20) @(negedge clk);
            oku(32'hC, r); kontrol++;
            if (r !== {24'd0, b}) begin hata++; $display("FAIL loop_random: got %h expected %h div=%0d", r, {24'd0, b}, d); end
        end
        geri_dongu = 0;
    endtask

    task automatic test_overrun;
        logic [7:0] q[$];
        logic [7:0] b;
        logic [31:0] r;
        int n, kap;
`ifdef UART_RX_FIFO_EN
        n = 9; kap = 8;
`else
        n = 2; kap = 1;
`endif
        yaz(32'h0, 32'h00030008, 4'hF);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            rx_gonder(b, 8, 1'b1);
            if (q.size() < kap) q.push_back(b);
        end
        repeat (10) @(negedge clk);
        oku(32'h4, r); kontrol++;
        if (r !== 32'hE) begin hata++; $display("FAIL overrun_set: got %h expected 0000000e", r); end
        yaz(32'h4, 32'h10, 4'hF);
        oku(32'h4, r); kontrol++;
        if (r !== 32'hE) begin hata++; $display("FAIL overrun_other_w1c: got %h expected 0000000e", r); end
        yaz(32'h4, 32'h8, 4'hF);
        oku(32'h4, r); kontrol++;
        if (r !== 32'h6) begin hata++; $display("FAIL overrun_clear: got %h expected 00000006", r); end
        while (q.size() > 0) begin
            b = q.pop_front();
            oku(32'hC, r); kontrol++;
            if (r !== {24'd0, b}) begin hata++; $display("FAIL overrun_kept_byte: got %h expected %h", r, {24'd0, b}); end
        end
        oku(32'h4, r); kontrol++;
        if (r !== 32'h2) begin hata++; $display("FAIL overrun_drained: got %h expected 00000002", r); end
    endtask

    task automatic test_glitch_frame;
        logic [31:0] r;
        yaz(32'h0, 32'h00030008, 4'hF);
        @(negedge clk); rx_surucu = 0;
        @(negedge clk); rx_surucu = 1;
        repeat (100) @(negedge clk);
        oku(32'h4, r); kontrol++;
        if (r !== 32'h2) begin hata++; $display("FAIL glitch_ignored: got %h expected 00000002", r); end
        rx_gonder(8'($urandom), 8, 1'b0);
        repeat (10) @(negedge clk);
        oku(32'h4, r); kontrol++;
        if (r !== 32'h12) begin hata++; $display("FAIL frame_err_set: got %h expected 00000012", r); end
        oku(32'hC, r); kontrol++;
        if (r !== 32'h0) begin hata++; $display("FAIL frame_err_discard: got %h expected 00000000", r); end
        yaz(32'h4, 32'h10, 4'hF);
        oku(32'h4, r); kontrol++;
        if (r !== 32'h2) begin hata++; $display("FAIL frame_err_clear: got %h expected 00000002", r); end
    endtask

    task automatic test_reset_mid_tx;
        logic [31:0] r;
        int bad = 0;
        yaz(32'h0, 32'h00030008, 4'hF);
        yaz(32'h8, 32'h00, 4'h1);
        yaz(32'h8, 32'h00, 4'h1);
        tx_yakala(20);
        kontrol++;
        if (uart_tx_o !== 1'b0) begin hata++; $display("FAIL mid_frame_low: got %b expected 0", uart_tx_o); end
        resetn = 0;
        #1;
        kontrol++;
        if (uart_tx_o !== 1'b1 || iomem_ready !== 1'b0) begin
            hata++; $display("FAIL async_reset_tx: got tx=%b ready=%b expected 1 0", uart_tx_o, iomem_ready);
        end
        repeat (2) @(negedge clk);
        resetn = 1;
        oku(32'h4, r); kontrol++;
        if (r !== 32'h2) begin hata++; $display("FAIL post_reset_durum: got %h expected 00000002", r); end
        oku(32'h0, r); kontrol++;
        if (r !== 32'h00030364) begin hata++; $display("FAIL post_reset_kontrol: got %h expected 00030364", r); end
        repeat (200) begin @(negedge clk); if (uart_tx_o !== 1'b1) bad++; end
        kontrol++;
        if (bad != 0) begin hata++; $display("FAIL post_reset_idle: got %0d low cycles expected 0", bad); end
    endtask

    initial begin
        test_reset;
        test_bus_timing;
        test_kontrol;
        test_tx_055;
        test_tx_rastgele;
        test_fifo_full;
        test_loopback;
        test_overrun;
        test_glitch_frame;
        test_reset_mid_tx;
        $display("Result: errors=%0d of %0d checks", hata, kontrol);
        $finish;
    end
endmodule
